uart_rx_frm: RTL

//  Serial front end of the Segway command path: turns the 8N1 RX line from the Bluetooth app into bytes.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_cnt.sv | 33 +++
 rtl/uart_rx_frm.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the Segway command UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int          BAUD_DIV_DEF = 5208;
  localparam int          CNT_W        = 13;

  localparam logic [7:0]  CMD_GO       = 8'h47;
  localparam logic [7:0]  CMD_STOP     = 8'h53;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: loadable 13-bit down-counter; o_tick is high while the count is zero,
// and the counter reloads to a full bit period on that same cycle unless loaded.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_tick
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = (r_cnt == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= RELOAD;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (o_tick) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_frm.sv
// uart_rx_frm: 8N1 receiver producing rx_data/rdy (clr_rdy handshake) and frm_err.
// Build option UART_RX_MAJ_VOTE_EN: each bit is a 2-of-3 vote of rx_s at cnt=2,1,0.
module uart_rx_frm
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);

  logic             r_sync1;
  logic             r_rx_s;
  logic             r_rx_d1;
  rx_state_t        r_state;
  logic [7:0]       r_shreg;
  logic [3:0]       r_bit_cnt;

  logic             w_tick;
  logic             w_fall;
  logic             w_bit;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_d1 <= 1'b1;
    end else begin
      r_sync1 <= RX;
      r_rx_s  <= r_sync1;
      r_rx_d1 <= r_rx_s;
    end
  end

  assign w_fall = ~r_rx_s & r_rx_d1;

`ifdef UART_RX_MAJ_VOTE_EN
  // The counter always runs down through 2,1,0 before a tick, so the rx_s
  // history at the tick holds exactly the samples taken at cnt=2 and cnt=1.
  logic r_rx_d2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_d2 <= 1'b1;
    end else begin
      r_rx_d2 <= r_rx_d1;
    end
  end

  assign w_bit = maj3(r_rx_d2, r_rx_d1, r_rx_s);
`else
  assign w_bit = r_rx_s;
`endif

  always_comb begin
    w_load     = 1'b0;
    w_load_val = FULL_M1;
    if (r_state == IDLE && w_fall) begin
      w_load     = 1'b1;
      w_load_val = HALF_M1;
    end else if (r_state == START && w_tick && !w_bit) begin
      w_load     = 1'b1;
      w_load_val = FULL_M1;
    end
  end

  uart_baud_cnt #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tick     (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      rx_data   <= '0;
      rdy       <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      // Clear first so a same-cycle set from STOP takes priority.
      if (clr_rdy) begin
        rdy <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state <= START;
          end
        end
        START: begin
          if (w_tick) begin
            if (w_bit) begin
              r_state <= IDLE;
            end else begin
              rdy       <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= DATA;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shreg   <= {w_bit, r_shreg[7:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              r_state <= STOP;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
            if (w_bit) begin
              rx_data <= r_shreg;
              rdy     <= 1'b1;
              frm_err <= 1'b0;
            end else begin
              frm_err <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
